pipe_stage_skid: RTL and testbench

- Parametrised successor to the fixed inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB); one instance replaces each hand-written stage register.
- Carries a generic data payload plus a control bundle between stages.
- Adds a valid/ready handshake for back-pressure (stall) and an optional 2-entry skid buffer, so ready is registered and full throughput is kept.
- Flush inserts a bubble with all control bits cleared, so a squashed instruction can never write registers or memory.

---
 rtl/pipe_stage_skid.sv | 85 ++++++++
 tb/tb_pipe_stage_skid.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, flush-to-bubble and optional 2-entry skid buffer.
// Latency 1 cycle; full throughput; SKID=1 registers in_ready (no out_ready->in_ready path), SKID=0 passes it through.
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    logic              r_main_vld;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic              r_skid_vld;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;

    logic w_acc;
    logic w_drn;

    generate
        if (SKID != 0) begin : g_skid
            assign in_ready = !r_skid_vld;
        end else begin : g_noskid
            assign in_ready = !r_main_vld | out_ready;
        end
    endgenerate

    assign w_acc = in_valid & in_ready;
    assign w_drn = r_main_vld & out_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_main_vld  <= 1'b0;
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_vld  <= 1'b0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else if (w_drn) begin
            if (r_skid_vld) begin
                // in_ready is low while skid is full, so no accept can collide here
                r_main_data <= r_skid_data;
                r_main_ctrl <= r_skid_ctrl;
                r_skid_vld  <= 1'b0;
                r_skid_ctrl <= '0;
            end else if (w_acc) begin
                r_main_data <= in_data;
                r_main_ctrl <= in_ctrl;
            end else begin
                r_main_vld  <= 1'b0;
                r_main_ctrl <= '0;
            end
        end else if (w_acc) begin
            if (!r_main_vld) begin
                r_main_vld  <= 1'b1;
                r_main_data <= in_data;
                r_main_ctrl <= in_ctrl;
            end else if (SKID != 0) begin
                r_skid_vld  <= 1'b1;
                r_skid_data <= in_data;
                r_skid_ctrl <= in_ctrl;
            end
        end
    end

    assign out_valid = r_main_vld;
    assign out_data  = r_main_data;
    assign out_ctrl  = r_main_ctrl;
    assign occupancy = 2'(r_main_vld) + 2'(r_skid_vld);

    a_skid_implies_main: assert property (@(posedge clk) disable iff (rst) r_skid_vld |-> r_main_vld);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: index 1 is a SKID=1 instance, index 0 a SKID=0 instance, sharing clk and rst.
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush     [2];
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [31:0] in_data   [2];
    logic [7:0]  in_ctrl   [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] out_data  [2];
    logic [7:0]  out_ctrl  [2];
    logic [1:0]  occ       [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(32), .CTRL_W(8), .SKID(0)) u_dut0 (
        .clk(clk), .rst(rst), .flush(flush[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_ctrl(in_ctrl[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .out_ctrl(out_ctrl[0]),
        .occupancy(occ[0])
    );

    pipe_stage_skid #(.DATA_W(32), .CTRL_W(8), .SKID(1)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_ctrl(in_ctrl[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .out_ctrl(out_ctrl[1]),
        .occupancy(occ[1])
    );

    task automatic idle(input int d);
        flush[d]     = 1'b0;
        in_valid[d]  = 1'b0;
        in_data[d]   = '0;
        in_ctrl[d]   = '0;
        out_ready[d] = 1'b0;
    endtask

    task automatic clear(input int d);
        @(negedge clk);
        idle(d);
        flush[d] = 1'b1;
        @(negedge clk);
        flush[d] = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b1;
            in_data[d]  = 32'hDEADBEEF;
            in_ctrl[d]  = 8'hFF;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) in_valid[d] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            total++;
            if (out_valid[d] !== 1'b0) begin bad++; $display("FAIL reset_out_valid dut%0d got=%b want=0", d, out_valid[d]); end
            total++;
            if (out_ctrl[d] !== 8'h00) begin bad++; $display("FAIL reset_out_ctrl dut%0d got=%h want=00", d, out_ctrl[d]); end
            total++;
            if (occ[d] !== 2'd0) begin bad++; $display("FAIL reset_occupancy dut%0d got=%0d want=0", d, occ[d]); end
            total++;
            if (in_ready[d] !== 1'b1) begin bad++; $display("FAIL reset_in_ready dut%0d got=%b want=1", d, in_ready[d]); end
        end
    endtask

    task automatic test_streaming();
        clear(1);
        out_ready[1] = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i > 1) begin
                total++;
                if (out_valid[1] !== 1'b1 || out_data[1] !== 32'(i - 1)) begin
                    bad++; $display("FAIL stream_beat got v=%b d=%h want v=1 d=%h", out_valid[1], out_data[1], i - 1);
                end
            end
            total++;
            if (in_ready[1] !== 1'b1) begin bad++; $display("FAIL stream_in_ready beat %0d got=%b want=1", i, in_ready[1]); end
            in_valid[1] = 1'b1;
            in_data[1]  = 32'(i);
            in_ctrl[1]  = 8'(i);
        end
        @(negedge clk);
        in_valid[1] = 1'b0;
        total++;
        if (out_valid[1] !== 1'b1 || out_data[1] !== 32'h10) begin
            bad++; $display("FAIL stream_last got v=%b d=%h want v=1 d=10", out_valid[1], out_data[1]);
        end
        @(negedge clk);
        total++;
        if (out_valid[1] !== 1'b0) begin bad++; $display("FAIL stream_empty got=%b want=0", out_valid[1]); end
        idle(1);
    endtask

    task automatic test_backpressure();
        clear(1);
        in_valid[1] = 1'b1; in_data[1] = 32'hA; in_ctrl[1] = 8'h11;
        @(negedge clk);
        in_data[1] = 32'hB; in_ctrl[1] = 8'h22;
        @(negedge clk);
        in_data[1] = 32'hC; in_ctrl[1] = 8'h33;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++;
            if (occ[1] !== 2'd2) begin bad++; $display("FAIL bp_occupancy got=%0d want=2", occ[1]); end
            total++;
            if (in_ready[1] !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", in_ready[1]); end
            total++;
            if (out_data[1] !== 32'hA || out_ctrl[1] !== 8'h11) begin
                bad++; $display("FAIL bp_head got d=%h c=%h want d=A c=11", out_data[1], out_ctrl[1]);
            end
        end
        out_ready[1] = 1'b1;
        @(negedge clk);
        total++;
        if (out_data[1] !== 32'hB || in_ready[1] !== 1'b1 || occ[1] !== 2'd1) begin
            bad++; $display("FAIL bp_second got d=%h rdy=%b occ=%0d want d=B rdy=1 occ=1", out_data[1], in_ready[1], occ[1]);
        end
        @(negedge clk);
        in_valid[1] = 1'b0;
        total++;
        if (out_data[1] !== 32'hC || out_ctrl[1] !== 8'h33 || out_valid[1] !== 1'b1) begin
            bad++; $display("FAIL bp_third got v=%b d=%h c=%h want v=1 d=C c=33", out_valid[1], out_data[1], out_ctrl[1]);
        end
        @(negedge clk);
        total++;
        if (out_valid[1] !== 1'b0 || occ[1] !== 2'd0) begin
            bad++; $display("FAIL bp_drained got v=%b occ=%0d want v=0 occ=0", out_valid[1], occ[1]);
        end
        idle(1);
    endtask

    task automatic test_flush_full();
        clear(1);
        in_valid[1] = 1'b1; in_data[1] = 32'h1111; in_ctrl[1] = 8'hFF;
        @(negedge clk);
        in_data[1] = 32'h2222;
        @(negedge clk);
        in_valid[1] = 1'b0;
        total++;
        if (occ[1] !== 2'd2) begin bad++; $display("FAIL flush_prefill got=%0d want=2", occ[1]); end
        flush[1] = 1'b1;
        @(negedge clk);
        flush[1] = 1'b0;
        total++;
        if (out_valid[1] !== 1'b0 || out_ctrl[1] !== 8'h00 || occ[1] !== 2'd0 || in_ready[1] !== 1'b1) begin
            bad++; $display("FAIL flush_full got v=%b c=%h occ=%0d rdy=%b want v=0 c=00 occ=0 rdy=1",
                            out_valid[1], out_ctrl[1], occ[1], in_ready[1]);
        end
    endtask

    task automatic test_flush_accept();
        for (int d = 0; d < 2; d++) begin
            clear(d);
            out_ready[d] = 1'b1;
            flush[d] = 1'b1; in_valid[d] = 1'b1; in_data[d] = 32'h55; in_ctrl[d] = 8'h0F;
            @(negedge clk);
            flush[d] = 1'b0; in_valid[d] = 1'b0;
            for (int k = 0; k < 2; k++) begin
                total++;
                if (out_valid[d] !== 1'b0 || out_ctrl[d] !== 8'h00) begin
                    bad++; $display("FAIL flush_accept dut%0d got v=%b d=%h c=%h want v=0 c=00", d, out_valid[d], out_data[d], out_ctrl[d]);
                end
                @(negedge clk);
            end
            idle(d);
        end
    endtask

    task automatic test_skid0_stall();
        clear(0);
        in_valid[0] = 1'b1; in_data[0] = 32'h0000_00A1; in_ctrl[0] = 8'h3C;
        @(negedge clk);
        in_data[0] = 32'h0000_00A2; in_ctrl[0] = 8'h5A;
        #1;
        total++;
        if (in_ready[0] !== 1'b0) begin bad++; $display("FAIL s0_stall_ready got=%b want=0", in_ready[0]); end
        out_ready[0] = 1'b1;
        #1;
        total++;
        if (in_ready[0] !== 1'b1) begin bad++; $display("FAIL s0_comb_ready got=%b want=1", in_ready[0]); end
        @(negedge clk);
        in_valid[0] = 1'b0;
        total++;
        if (out_valid[0] !== 1'b1 || out_data[0] !== 32'hA2 || out_ctrl[0] !== 8'h5A) begin
            bad++; $display("FAIL s0_replace got v=%b d=%h c=%h want v=1 d=A2 c=5A", out_valid[0], out_data[0], out_ctrl[0]);
        end
        @(negedge clk);
        total++;
        if (out_valid[0] !== 1'b0 || out_ctrl[0] !== 8'h00 || occ[0] !== 2'd0) begin
            bad++; $display("FAIL s0_bubble got v=%b c=%h occ=%0d want v=0 c=00 occ=0", out_valid[0], out_ctrl[0], occ[0]);
        end
        idle(0);
    endtask

    // Reference: the stage is a FIFO of capacity 2 (SKID=1) or 1 with pass-through ready (SKID=0)
    task automatic test_random(input int d, input int n);
        logic [39:0] q[$];
        logic        rdy;
        clear(d);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            total++;
            if (out_valid[d] !== (q.size() > 0)) begin
                bad++; $display("FAIL rand_valid dut%0d cyc %0d got=%b want=%b", d, c, out_valid[d], q.size() > 0);
            end
            total++;
            if (q.size() > 0) begin
                if ({out_ctrl[d], out_data[d]} !== q[0]) begin
                    bad++; $display("FAIL rand_head dut%0d cyc %0d got=%h want=%h", d, c, {out_ctrl[d], out_data[d]}, q[0]);
                end
            end else if (out_ctrl[d] !== 8'h00) begin
                bad++; $display("FAIL rand_bubble_ctrl dut%0d cyc %0d got=%h want=00", d, c, out_ctrl[d]);
            end
            total++;
            if (occ[d] !== 2'(q.size())) begin
                bad++; $display("FAIL rand_occupancy dut%0d cyc %0d got=%0d want=%0d", d, c, occ[d], q.size());
            end
            in_valid[d]  = ($urandom_range(0, 3) != 0);
            in_data[d]   = $urandom;
            in_ctrl[d]   = 8'($urandom);
            out_ready[d] = ($urandom_range(0, 3) != 0);
            flush[d]     = ($urandom_range(0, 19) == 0);
            rdy = (d == 1) ? (q.size() < 2) : (q.size() == 0 || out_ready[d]);
            #1;
            total++;
            if (in_ready[d] !== rdy) begin
                bad++; $display("FAIL rand_in_ready dut%0d cyc %0d got=%b want=%b", d, c, in_ready[d], rdy);
            end
            if (flush[d]) begin
                q.delete();
            end else begin
                if (q.size() > 0 && out_ready[d]) void'(q.pop_front());
                if (in_valid[d] && rdy) q.push_back({in_ctrl[d], in_data[d]});
            end
        end
        @(negedge clk);
        idle(d);
    endtask

    initial begin
        rst = 1'b1;
        idle(0);
        idle(1);
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_full();
        test_flush_accept();
        test_skid0_stall();
        test_random(1, 600);
        test_random(0, 600);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
